// File: rtl/nibble_add_sequencer.sv
// ============================================================================
//  Module      : nibble_add_sequencer
//  Description : Drives one external 4-bit full adder, one nibble per cycle,
//                LSB nibble first, to build a WIDTH-bit add.
//                Optional overflow flag port ovf_out under OVF_DETECT_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module nibble_add_sequencer #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             cin_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum_out,
   output logic             cout_out,
   output logic [3:0]       add_a,
   output logic [3:0]       add_b,
   output logic             add_cin,
   input  logic [3:0]       add_sum,
   input  logic             add_cout
`ifdef OVF_DETECT_EN
   ,
   output logic             ovf_out
`endif
);

   localparam int NIB  = WIDTH / 4;
   localparam int IDXW = $clog2(NIB);
   localparam logic [IDXW-1:0] C_LAST_IDX = IDXW'(NIB - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [IDXW-1:0]  idx_q, idx_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
`ifdef OVF_DETECT_EN
   logic             ovf_q, ovf_d;
`endif

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
`ifdef OVF_DETECT_EN
      ovf_d   = ovf_q;
`endif
      add_a   = 4'd0;
      add_b   = 4'd0;
      add_cin = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d     = a_in;
               b_d     = b_in;
               carry_d = cin_in;
               idx_d   = '0;
               sum_d   = '0;
               cout_d  = 1'b0;
`ifdef OVF_DETECT_EN
               ovf_d   = 1'b0;
`endif
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            // Adder is combinational: its result for this nibble is ready now.
            add_a   = a_q[{idx_q, 2'b00} +: 4];
            add_b   = b_q[{idx_q, 2'b00} +: 4];
            add_cin = carry_q;
            sum_d[{idx_q, 2'b00} +: 4] = add_sum;
            carry_d = add_cout;
            idx_d   = idx_q + IDXW'(1);
            if (idx_q == C_LAST_IDX) begin
               cout_d  = add_cout;
`ifdef OVF_DETECT_EN
               ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_sum[3] != a_q[WIDTH-1]);
`endif
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
`ifdef OVF_DETECT_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
`ifdef OVF_DETECT_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign busy     = (state_q != S_IDLE);
   assign done     = (state_q == S_DONE);
   assign sum_out  = sum_q;
   assign cout_out = cout_q;
`ifdef OVF_DETECT_EN
   assign ovf_out  = ovf_q;
`endif

endmodule

`default_nettype wire
